// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: walks a program counter from a launch address,
// follows relative branches, stops on halt and counts executed instructions.
//
// state | meaning
// IDLE  | waiting for Start after reset; all registers hold
// RUN   | one instruction executed per cycle, ProgCtr advances
// DONE  | halt seen; ProgCtr/InstrCount frozen, Done high, Start relaunches
module fetch_unit #(
  parameter int PC_W    = 10,
  parameter int INSTR_W = 9,
  parameter int CNT_W   = 16
) (
  input  logic               Clk,
  input  logic               ResetN,
  input  logic               Start,
  input  logic [PC_W-1:0]    StartAddr,
  input  logic               BranchRel,
  input  logic               BranchTaken,
  input  logic [PC_W-1:0]    BranchOffset,
  input  logic               Halt,
  input  logic [INSTR_W-1:0] InstrIn,
  output logic [PC_W-1:0]    ProgCtr,
  output logic [INSTR_W-1:0] Instruction,
  output logic               InstrValid,
  output logic               Done,
  output logic [CNT_W-1:0]   InstrCount
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc_q, pc_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              done_q;

  always_ff @(posedge Clk) begin
    if (!ResetN) begin
      state  <= IDLE;
      pc_q   <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc_q   <= pc_nxt;
      cnt_q  <= cnt_nxt;
      done_q <= (state_nxt == DONE);
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc_q;
    cnt_nxt   = cnt_q;
    case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = StartAddr;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        // the halt instruction itself is counted; counter saturates, never wraps
        cnt_nxt = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
        if (Halt) begin
          state_nxt = DONE;
        end else if (BranchRel && BranchTaken) begin
          pc_nxt = pc_q + BranchOffset;
        end else begin
          pc_nxt = pc_q + PC_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    InstrValid  = (state == RUN);
    Instruction = InstrValid ? InstrIn : '0;
  end

  assign ProgCtr    = pc_q;
  assign InstrCount = cnt_q;
  assign Done       = done_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: launch, branches, wrap, halt/relaunch,
// reset abort, and counter saturation on a narrow-counter instance.
module tb_fetch_unit;

  logic        Clk;
  logic        ResetN;
  logic        Start;
  logic [9:0]  StartAddr;
  logic        BranchRel;
  logic        BranchTaken;
  logic [9:0]  BranchOffset;
  logic        Halt;
  logic [8:0]  InstrIn;
  logic [9:0]  ProgCtr;
  logic [8:0]  Instruction;
  logic        InstrValid;
  logic        Done;
  logic [15:0] InstrCount;

  logic [8:0]  InstrIn4;
  logic [9:0]  ProgCtr4;
  logic [8:0]  Instruction4;
  logic        InstrValid4;
  logic        Done4;
  logic [3:0]  InstrCount4;

  int total = 0;
  int bad   = 0;

  // instruction memory image: a fixed scramble of the address
  function automatic logic [8:0] mem(input logic [9:0] a);
    return a[8:0] ^ 9'h1A5;
  endfunction

  assign InstrIn  = mem(ProgCtr);
  assign InstrIn4 = mem(ProgCtr4);

  fetch_unit dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
    .BranchRel(BranchRel), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .Halt(Halt), .InstrIn(InstrIn), .ProgCtr(ProgCtr), .Instruction(Instruction),
    .InstrValid(InstrValid), .Done(Done), .InstrCount(InstrCount)
  );

  fetch_unit #(.CNT_W(4)) dut4 (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .StartAddr(StartAddr),
    .BranchRel(BranchRel), .BranchTaken(BranchTaken), .BranchOffset(BranchOffset),
    .Halt(Halt), .InstrIn(InstrIn4), .ProgCtr(ProgCtr4), .Instruction(Instruction4),
    .InstrValid(InstrValid4), .Done(Done4), .InstrCount(InstrCount4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clear_inputs();
    Start = 1'b0; StartAddr = '0; BranchRel = 1'b0; BranchTaken = 1'b0;
    BranchOffset = '0; Halt = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    ResetN = 1'b0;
    step();
    ResetN = 1'b1;
  endtask

  task automatic launch(input logic [9:0] addr);
    Start = 1'b1; StartAddr = addr;
    step();
    Start = 1'b0; StartAddr = '0;
  endtask

  task automatic test_reset();
    ResetN = 1'b0; Start = 1'b1; StartAddr = 10'h155; Halt = 1'b1;
    BranchRel = 1'b1; BranchTaken = 1'b1; BranchOffset = 10'h005;
    step();
    total++; if (ProgCtr !== 10'h000) begin bad++; $display("FAIL reset_pc got=%h exp=000", ProgCtr); end
    total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", InstrCount); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", InstrValid); end
    total++; if (Instruction !== 9'h000) begin bad++; $display("FAIL reset_instr got=%h exp=000", Instruction); end
    ResetN = 1'b1;
    clear_inputs();
    step();
    total++; if (ProgCtr !== 10'h000 || InstrValid !== 1'b0) begin
      bad++; $display("FAIL idle_hold pc=%h valid=%b exp pc=000 valid=0", ProgCtr, InstrValid); end
  endtask

  task automatic test_launch();
    do_reset();
    launch(10'h010);
    total++; if (ProgCtr !== 10'h010) begin bad++; $display("FAIL launch_pc got=%h exp=010", ProgCtr); end
    total++; if (InstrValid !== 1'b1) begin bad++; $display("FAIL launch_valid got=%b exp=1", InstrValid); end
    total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL launch_cnt got=%0d exp=0", InstrCount); end
    total++; if (Instruction !== 9'h1B5) begin bad++; $display("FAIL launch_instr got=%h exp=1b5", Instruction); end
    repeat (3) step();
    total++; if (ProgCtr !== 10'h013) begin bad++; $display("FAIL seq3_pc got=%h exp=013", ProgCtr); end
    total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL seq3_cnt got=%0d exp=3", InstrCount); end
    total++; if (Instruction !== 9'h1B6) begin bad++; $display("FAIL seq3_instr got=%h exp=1b6", Instruction); end
  endtask

  task automatic test_branch();
    do_reset();
    launch(10'h020);
    BranchRel = 1'b1; BranchTaken = 1'b1; BranchOffset = 10'h3FC;
    step();
    total++; if (ProgCtr !== 10'h01C) begin bad++; $display("FAIL br_back_pc got=%h exp=01c", ProgCtr); end
    total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL br_back_cnt got=%0d exp=1", InstrCount); end
    do_reset();
    launch(10'h020);
    BranchRel = 1'b1; BranchTaken = 1'b0; BranchOffset = 10'h3FC;
    step();
    total++; if (ProgCtr !== 10'h021) begin bad++; $display("FAIL br_not_taken_pc got=%h exp=021", ProgCtr); end
    BranchTaken = 1'b1; BranchOffset = 10'h000;
    repeat (2) step();
    total++; if (ProgCtr !== 10'h021) begin bad++; $display("FAIL br_self_loop_pc got=%h exp=021", ProgCtr); end
    total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL br_self_loop_cnt got=%0d exp=3", InstrCount); end
    clear_inputs();
    Start = 1'b1; StartAddr = 10'h155;
    step();
    Start = 1'b0;
    total++; if (ProgCtr !== 10'h022) begin bad++; $display("FAIL start_in_run_pc got=%h exp=022", ProgCtr); end
    total++; if (InstrCount !== 16'd4) begin bad++; $display("FAIL start_in_run_cnt got=%0d exp=4", InstrCount); end
  endtask

  task automatic test_wrap();
    do_reset();
    launch(10'h3FF);
    step();
    total++; if (ProgCtr !== 10'h000) begin bad++; $display("FAIL wrap_seq_pc got=%h exp=000", ProgCtr); end
    do_reset();
    launch(10'h3FE);
    BranchRel = 1'b1; BranchTaken = 1'b1; BranchOffset = 10'h005;
    step();
    total++; if (ProgCtr !== 10'h003) begin bad++; $display("FAIL wrap_br_pc got=%h exp=003", ProgCtr); end
    clear_inputs();
  endtask

  task automatic test_halt();
    do_reset();
    launch(10'h040);
    Halt = 1'b1; BranchRel = 1'b1; BranchTaken = 1'b1; BranchOffset = 10'h010;
    step();
    clear_inputs();
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL halt_done got=%b exp=1", Done); end
    total++; if (ProgCtr !== 10'h040) begin bad++; $display("FAIL halt_pc got=%h exp=040", ProgCtr); end
    total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL halt_valid got=%b exp=0", InstrValid); end
    total++; if (Instruction !== 9'h000) begin bad++; $display("FAIL halt_instr got=%h exp=000", Instruction); end
    total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL halt_cnt got=%0d exp=1", InstrCount); end
    step();
    total++; if (Done !== 1'b1 || ProgCtr !== 10'h040 || InstrCount !== 16'd1) begin
      bad++; $display("FAIL done_hold done=%b pc=%h cnt=%0d exp done=1 pc=040 cnt=1", Done, ProgCtr, InstrCount); end
    launch(10'h000);
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL relaunch_done got=%b exp=0", Done); end
    total++; if (ProgCtr !== 10'h000) begin bad++; $display("FAIL relaunch_pc got=%h exp=000", ProgCtr); end
    total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL relaunch_cnt got=%0d exp=0", InstrCount); end
    total++; if (InstrValid !== 1'b1) begin bad++; $display("FAIL relaunch_valid got=%b exp=1", InstrValid); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    launch(10'h100);
    repeat (2) step();
    total++; if (ProgCtr !== 10'h102) begin bad++; $display("FAIL midrun_pre_pc got=%h exp=102", ProgCtr); end
    ResetN = 1'b0; Start = 1'b1; StartAddr = 10'h2AA;
    BranchRel = 1'b1; BranchTaken = 1'b1; BranchOffset = 10'h007;
    step();
    total++; if (ProgCtr !== 10'h000) begin bad++; $display("FAIL midrun_pc got=%h exp=000", ProgCtr); end
    total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL midrun_cnt got=%0d exp=0", InstrCount); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL midrun_done got=%b exp=0", Done); end
    total++; if (InstrValid !== 1'b0) begin bad++; $display("FAIL midrun_valid got=%b exp=0", InstrValid); end
    ResetN = 1'b1;
    clear_inputs();
    step();
    total++; if (ProgCtr !== 10'h000 || InstrValid !== 1'b0) begin
      bad++; $display("FAIL midrun_idle pc=%h valid=%b exp pc=000 valid=0", ProgCtr, InstrValid); end
  endtask

  task automatic test_saturation();
    do_reset();
    launch(10'h000);
    repeat (14) step();
    total++; if (InstrCount4 !== 4'd14) begin bad++; $display("FAIL sat_pre_cnt got=%0d exp=14", InstrCount4); end
    repeat (6) step();
    total++; if (InstrCount4 !== 4'd15) begin bad++; $display("FAIL sat_cnt got=%0d exp=15", InstrCount4); end
    total++; if (InstrCount !== 16'd20) begin bad++; $display("FAIL wide_cnt got=%0d exp=20", InstrCount); end
    total++; if (ProgCtr4 !== 10'h014) begin bad++; $display("FAIL sat_pc got=%h exp=014", ProgCtr4); end
  endtask

  initial begin
    clear_inputs();
    ResetN = 1'b0;
    test_reset();
    test_launch();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_mid_run();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
